// File: rtl/vga_char_buffer_ctrl_pkg.sv
// Shared types and constants for the VGA character buffer controller.
package vga_ctrl_pkg;

  typedef enum logic [1:0] {
    CMD_NOP    = 2'b00,
    CMD_CLEAR  = 2'b01,
    CMD_SCROLL = 2'b10,
    CMD_RSVD   = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_CLEAR,
    ST_SCROLL
  } ctrl_state_e;

  localparam logic [7:0] BLANK_CHAR_DEF = 8'h20;

endpackage

// File: rtl/vga_char_buffer_ctrl_if.sv
// CPU-side write and bulk-command handshake bundle for the character buffer.
interface vga_char_buffer_ctrl_if #(
  parameter int ADDR_W = 8
);
  import vga_ctrl_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              cmd_valid;
  logic              cmd_ready;
  cmd_op_e           cmd_op;

  modport master (
    output wr_valid, wr_addr, wr_data, cmd_valid, cmd_op,
    input  wr_ready, cmd_ready
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, cmd_valid, cmd_op,
    output wr_ready, cmd_ready
  );

endinterface

// File: rtl/vga_char_buffer_ctrl_fifo.sv
// char_wr_fifo: first-word-fall-through queue of pending {addr,data} CPU writes.
module char_wr_fifo #(
  parameter int  ADDR_W = 8,
  parameter int  DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_data,
  input  logic              i_pop,
  output logic [ADDR_W-1:0] o_addr,
  output logic [7:0]        o_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [CNT_W-1:0]  o_count
);

  logic [ADDR_W+7:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign {o_addr, o_data} = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {i_addr, i_data};
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vga_char_buffer_ctrl.sv
// Character buffer owner: queues CPU writes and CLEAR/SCROLL, committing only during vblank.
// Optional macro VGA_TEAR_BYPASS_EN removes the vblank gating (every cycle may update memory).
module vga_char_buffer_ctrl
  import vga_ctrl_pkg::*;
#(
  parameter int         ENTRIES    = 256,
  parameter int         COLS       = 16,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] BLANK_CHAR = BLANK_CHAR_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_vblank,
  vga_char_buffer_ctrl_if.slave         bus,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic [7:0]                    o_char_data [ENTRIES]
);

  localparam int ADDR_W = $clog2(ENTRIES);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  ctrl_state_e       r_state;
  logic [ADDR_W-1:0] r_index;
  logic [7:0]        r_char_data [ENTRIES];

  logic              w_gate;
  logic              w_push;
  logic              w_pop;
  logic              w_cmd_fire;
  logic              w_last;
  logic              w_full;
  logic              w_empty;
  logic [ADDR_W-1:0] w_fifo_addr;
  logic [7:0]        w_fifo_data;
  logic [CNT_W-1:0]  w_fifo_count;

`ifdef VGA_TEAR_BYPASS_EN
  assign w_gate = 1'b1;
`else
  assign w_gate = i_vblank;
`endif

  assign bus.wr_ready  = !w_full;
  assign bus.cmd_ready = (r_state == ST_IDLE) && w_empty;
  assign o_busy        = (r_state != ST_IDLE) || !w_empty;
  assign o_fifo_count  = w_fifo_count;

  assign w_push     = bus.wr_valid && bus.wr_ready;
  assign w_cmd_fire = bus.cmd_valid && bus.cmd_ready;
  assign w_pop      = (r_state == ST_DRAIN) && w_gate && !w_empty;
  assign w_last     = (r_index == ADDR_W'(ENTRIES - 1));

  char_wr_fifo #(
    .ADDR_W (ADDR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_addr  (bus.wr_addr),
    .i_data  (bus.wr_data),
    .i_pop   (w_pop),
    .o_addr  (w_fifo_addr),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_index <= '0;
      for (int i = 0; i < ENTRIES; i++) r_char_data[i] <= BLANK_CHAR;
    end else begin
      case (r_state)
        // A command accepted alongside a write runs first; the write drains afterwards.
        ST_IDLE: begin
          if (w_cmd_fire && bus.cmd_op == CMD_CLEAR) begin
            r_state <= ST_CLEAR;
            r_index <= '0;
          end else if (w_cmd_fire && bus.cmd_op == CMD_SCROLL) begin
            r_state <= ST_SCROLL;
            r_index <= '0;
          end else if (!w_empty) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_empty) begin
            r_state <= ST_IDLE;
          end else if (w_pop) begin
            r_char_data[w_fifo_addr] <= w_fifo_data;
            if (w_fifo_count == CNT_W'(1) && !w_push) r_state <= ST_IDLE;
          end
        end
        ST_CLEAR, ST_SCROLL: begin
          if (w_gate) begin
            if (r_state == ST_SCROLL && int'(r_index) < ENTRIES - COLS)
              r_char_data[r_index] <= r_char_data[r_index + ADDR_W'(COLS)];
            else
              r_char_data[r_index] <= BLANK_CHAR;
            if (w_last) begin
              r_index <= '0;
              r_state <= w_empty ? ST_IDLE : ST_DRAIN;
            end else begin
              r_index <= r_index + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_out
    assign o_char_data[gi] = r_char_data[gi];
  end

endmodule

// File: doc/vga_char_buffer_ctrl.md
Name: vga_char_buffer_ctrl

Overview:
Owns the character buffer array that feeds the VGA text renderer's char_data input. Arbitrates between CPU single-character writes and bulk commands (CLEAR, SCROLL).
- Commits all buffer changes only during vertical blanking, so a frame never shows a half-updated screen.
- Sits between the CPU store path and the VGA top level.
- Clocked by the system clock.

Parameters:
ENTRIES, 256, number of character cells (rows*COLS); ADDR_W = $clog2(ENTRIES) is a derived localparam.
COLS, 16, characters per row; SCROLL shifts by COLS cells.
FIFO_DEPTH, 4, pending CPU write slots (power of 2).
BLANK_CHAR, 8'h20, fill value for reset, CLEAR and scrolled-in row.

Ports:
clk  in  1  system clock, single clock domain.
reset  in  1  asynchronous, active-low; 0 = reset asserted.
vblank  in  1  high while the vertical sync counter is outside the visible area.
wr_valid  in  1  CPU write request.
wr_ready  out  1  write accepted when wr_valid && wr_ready.
wr_addr  in  ADDR_W  target cell.
wr_data  in  8  character code.
cmd_valid  in  1  bulk command request.
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
cmd_op  in  2  00 NOP, 01 CLEAR, 10 SCROLL, 11 reserved (treated as NOP).
busy  out  1  state != IDLE or FIFO non-empty.
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied FIFO slots.
char_data  out  8 x ENTRIES  unpacked array, registered, drives the renderer.

Behaviour:
- Reset (reset=0, async):
  - every char_data entry = BLANK_CHAR; FIFO empty; state IDLE; scan index 0.
  - Outputs: wr_ready=1, cmd_ready=1, busy=0, fifo_count=0.
- wr_ready = FIFO not full.
  - An accepted write is enqueued at the clock edge.
  - A simultaneous pop and push on a full FIFO is not allowed: wr_ready depends on fullness only.
- cmd_ready = (state==IDLE) && FIFO empty.
  - NOP and reserved codes are accepted and leave state unchanged.
- FSM states: IDLE, DRAIN, CLEAR, SCROLL. Memory operations happen only in cycles where vblank=1.
  - In any non-IDLE state with vblank=0, index and FIFO are held; the operation resumes on the next vblank cycle.
- IDLE:
  - CLEAR accepted -> CLEAR, index=0.
  - SCROLL accepted -> SCROLL, index=0.
  - Otherwise, FIFO non-empty -> DRAIN.
- DRAIN: each vblank cycle pops one entry and writes char_data[addr]=data. When the last entry is popped -> IDLE.
- CLEAR: each vblank cycle writes char_data[index]=BLANK_CHAR and increments index. After index ENTRIES-1 -> IDLE, or DRAIN if the FIFO is non-empty.
- SCROLL: each vblank cycle:
  - index < ENTRIES-COLS: char_data[index] = char_data[index+COLS].
  - otherwise: char_data[index] = BLANK_CHAR.
  - Ends after index ENTRIES-1, with the same exit as CLEAR.
- Latency: ENTRIES vblank cycles per CLEAR or SCROLL; one vblank cycle per queued write.
- Same-cycle write and command acceptance: the command executes first, then the write drains. Result = the write lands on the cleared or scrolled buffer.
- Writes accepted during CLEAR/SCROLL queue up; wr_ready drops when FIFO_DEPTH entries are pending.
- Duplicate addresses in the FIFO: writes apply in FIFO order, so the last one wins.
- Reset mid-operation aborts immediately and returns to reset values; no partial state survives.

Optional Feature:
VGA_TEAR_BYPASS_EN
- Defined: the vblank gating is removed. Every memory operation proceeds every cycle, so CLEAR/SCROLL take exactly ENTRIES cycles and tearing is possible.
- Undefined: operations are gated by vblank as above.

Decomposition:
- Package vga_ctrl_pkg:
  - cmd_op_e enum (NOP, CLEAR, SCROLL, RSVD).
  - ctrl_state_e enum.
  - default BLANK_CHAR constant.
- One sub-module, char_wr_fifo: synchronous FIFO of {addr,data} with FIFO_DEPTH, full/empty/count, async active-low reset.

Test Plan:
1. Reset released, vblank=1 -> all char_data = 8'h20, busy=0, wr_ready=1, cmd_ready=1.
2. Write addr=5 data=8'h41 with vblank=0 for 10 cycles -> char_data[5] unchanged, fifo_count=1, busy=1. Raise vblank -> char_data[5]=8'h41 on the next edge, fifo_count=0.
3. Preload char_data[16]=8'h42, then SCROLL with vblank=1 -> after 256 cycles char_data[0]=8'h42 and char_data[240..255]=8'h20. Toggling vblank low for 20 cycles mid-scroll adds exactly 20 cycles.
4. CLEAR accepted; 5 writes attempted during CLEAR -> 4 accepted, wr_ready=0 on the 5th. After CLEAR the 4 land in order; the 5th is accepted once a slot frees.
5. Same-cycle SCROLL + write (addr 250, 8'h43) -> after completion char_data[250]=8'h43.
6. reset=0 asserted mid-CLEAR at index 100 -> immediately all entries 8'h20, state IDLE, FIFO empty.
